vga_console_ctrl: RTL and testbench
===================================

# vga_console_ctrl

Text-console sequencer that drives the write port of the VGA character memory. Accepts a byte stream through a valid/ready handshake and interprets printable characters and a small set of control codes. Maintains a cursor and issues one character-cell write per cycle. Also runs multi-cycle clear sequences for the full screen and for a single line. Sits between the keyboard/UART byte source and the character memory; the VGA scan side is untouched.

## Interface
- ROWS, 30, screen rows; row address 5 bits, legal rows 0..ROWS-1
- COLS, 70, screen columns; column address 7 bits, legal columns 0..COLS-1
- DEF_FG, 3'b111, foreground colour used by clear sequences
- DEF_BG, 3'b000, background colour used by clear sequences
- BLINK_CYCLES, 25_000_000, half-period of cursor blink, in clk cycles
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  byte available
- in_data  in  8  byte value
- in_ready  out  1  controller can accept a byte
- cfg_fg  in  3  foreground for printable writes, sampled at handshake
- cfg_bg  in  3  background for printable writes, sampled at handshake
- we  out  1  write strobe to character memory
- wr_addr  out  5  write row
- wc_addr  out  7  write column
- w_ascii  out  8  write character
- w_fg_color  out  3  write foreground
- w_bg_color  out  3  write background
- cur_row  out  5  cursor row
- cur_col  out  7  cursor column
- cur_vis  out  1  cursor visibility phase
- busy  out  1  clear sequence in progress

## Operation
- FSM states: CLR_SCR, CLR_LINE, IDLE.
- Handshake occurs when in_valid && in_ready. in_ready = (state == IDLE).
- After reset release, the FSM enters CLR_SCR.
- Printable bytes 0x20..0x7E:
  - Write {cur_row, cur_col, in_data, cfg_fg, cfg_bg}.
  - If cur_col < COLS-1, the cursor advances to cur_col+1.
  - Otherwise the cursor wraps to column 0 of the next row (see below).
- 0x0A (LF): move to column 0 of the next row; no character write.
- 0x0D (CR): cur_col <= 0; no write.
- 0x08 (BS):
  - If cur_col > 0: cur_col <= cur_col-1 and write 0x20 with DEF_FG/DEF_BG at the new position.
  - At column 0: accepted, no effect.
- 0x0C (FF): enter CLR_SCR.
- All other bytes are accepted and ignored.
- Next row:
  - The next row is cur_row+1, or 0 when cur_row == ROWS-1.
  - Entering a new row always enters CLR_LINE for that row.
- CLR_LINE:
  - Writes 0x20 with DEF_FG/DEF_BG to columns 0..COLS-1 of cur_row, one per cycle.
  - Then returns to IDLE with the cursor at (cur_row, 0).
- CLR_SCR:
  - Writes 0x20 with DEF colours to every cell, row-major: (0,0), (0,1), ..., (ROWS-1, COLS-1), one per cycle.
  - Then returns to IDLE with the cursor at (0,0).
- busy = (state != IDLE).
- Addresses emitted are never outside ROWS x COLS.

## Timing
- All write-port outputs are registered.
- Handshake at edge N produces we=1 with the corresponding data during cycle N+1. The cursor update is visible at the same edge.
- we is 1 for exactly one cycle per printable or BS write. Back-to-back bytes sustain one write per cycle.
- CLR_LINE holds we=1 for COLS consecutive cycles; in_ready=1 on the cycle after the last write.
- CLR_SCR holds we=1 for ROWS*COLS consecutive cycles (2100 with defaults).
- A printable in the last column triggers no extra gap: the character write occurs, then CLR_LINE writes start the following cycle.
- Reset values: we=0, wr_addr=0, wc_addr=0, w_ascii=0, w_fg_color=0, w_bg_color=0, cur_row=0, cur_col=0, cur_vis=1, in_ready=0, busy=1.
- Reset asserted mid-clear aborts the clear immediately. The clear restarts from (0,0) after release.
- in_data, cfg_fg and cfg_bg are don't-care when no handshake occurs.

## Configuration
- VGA_CONSOLE_BLINK_EN defined:
  - A counter toggles cur_vis every BLINK_CYCLES cycles.
  - Any handshake reloads the counter and forces cur_vis=1.
- VGA_CONSOLE_BLINK_EN undefined: there is no counter and cur_vis is constant 1.

## Structure
- Package vga_console_pkg holds:
  - the state enum (CLR_SCR, CLR_LINE, IDLE)
  - control-code constants CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D, CC_SPACE=8'h20
- One sub-module, vga_cursor_blink: the blink counter, instantiated only under VGA_CONSOLE_BLINK_EN.

## Test plan
- Reset, then wait for the screen clear:
  - Exactly 2100 we pulses, first at (0,0), last at (29,69).
  - All writes are 0x20/7/0.
  - in_ready rises afterward.
- Send "A" (0x41) with cfg_fg=3'b010, cfg_bg=3'b001:
  - One write of (0,0,0x41,2,1).
  - Cursor moves to (0,1).
- Send 70 printables starting at (0,0):
  - The last write is at (0,69).
  - 70 clear writes follow on row 1.
  - Cursor ends at (1,0).
- With the cursor at (29,5), send 0x0A:
  - Row 0 cleared in 70 writes.
  - Cursor ends at (0,0).
- Backspace cases:
  - At (3,4), send 0x08: write 0x20 at (3,3); cursor at (3,3).
  - At (3,0), send 0x08: no write; cursor stays.
- Send 0x0C mid-screen, then assert rst_n=0 at clear-cycle 500:
  - we drops to 0 immediately.
  - After release, a full 2100-cycle clear restarts from (0,0).

Source files
------------

// File: rtl/vga_console_pkg.sv
// vga_console_pkg: shared types for the VGA text-console sequencer.
// Holds the sequencer state enum, control-code constants and the write bundle.
package vga_console_pkg;

    typedef enum logic [1:0] {
        CLR_SCR  = 2'd0,
        CLR_LINE = 2'd1,
        IDLE     = 2'd2
    } state_t;

    localparam logic [7:0] CC_BS     = 8'h08;
    localparam logic [7:0] CC_LF     = 8'h0A;
    localparam logic [7:0] CC_FF     = 8'h0C;
    localparam logic [7:0] CC_CR     = 8'h0D;
    localparam logic [7:0] CC_SPACE  = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    // One character-cell write as presented to the character memory.
    typedef struct packed {
        logic [4:0] row;
        logic [6:0] col;
        logic [7:0] ascii;
        logic [2:0] fg;
        logic [2:0] bg;
    } cell_wr_t;

endpackage

// File: rtl/vga_cursor_blink.sv
// vga_cursor_blink: free-running cursor blink phase, reloaded on activity.
// Ports: clk, rst_n (async low), reload (restart phase, show cursor), vis.
module vga_cursor_blink #(
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic vis
);

    localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          vis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            vis_q <= 1'b1;
        end else if (reload) begin
            cnt_q <= '0;
            vis_q <= 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            vis_q <= ~vis_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign vis = vis_q;

endmodule

// File: rtl/vga_console_ctrl.sv
// vga_console_ctrl: byte-stream text console driving the VGA char-memory write port.
// Ports: clk, rst_n (async low); in_valid/in_data/in_ready byte handshake with
// cfg_fg/cfg_bg colours; we/wr_addr/wc_addr/w_ascii/w_fg_color/w_bg_color write
// port (registered); cur_row/cur_col/cur_vis cursor; busy while clearing.
// Define VGA_CONSOLE_BLINK_EN to blink cur_vis; otherwise cur_vis is held at 1.
module vga_console_ctrl
    import vga_console_pkg::*;
#(
    parameter int         ROWS   = 30,
    parameter int         COLS   = 70,
    parameter logic [2:0] DEF_FG = 3'b111,
    parameter logic [2:0] DEF_BG = 3'b000
`ifdef VGA_CONSOLE_BLINK_EN
    ,
    parameter int         BLINK_CYCLES = 25_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [2:0] cfg_fg,
    input  logic [2:0] cfg_bg,
    output logic       we,
    output logic [4:0] wr_addr,
    output logic [6:0] wc_addr,
    output logic [7:0] w_ascii,
    output logic [2:0] w_fg_color,
    output logic [2:0] w_bg_color,
    output logic [4:0] cur_row,
    output logic [6:0] cur_col,
    output logic       cur_vis,
    output logic       busy
);

    localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
    localparam logic [6:0] COL_LAST = 7'(COLS - 1);

    state_t     state_q, state_d;
    logic [4:0] clr_row_q, clr_row_d;
    logic [6:0] clr_col_q, clr_col_d;
    logic       clr_done_q, clr_done_d;
    logic [4:0] cur_row_q, cur_row_d;
    logic [6:0] cur_col_q, cur_col_d;
    logic       we_q, we_d;
    cell_wr_t   wr_q, wr_d;

    logic       hs;
    logic       is_print;
    logic       new_line;
    logic [4:0] row_next;

    assign hs       = in_valid && (state_q == IDLE);
    assign is_print = (in_data >= CC_SPACE) && (in_data <= PRINT_MAX);
    assign row_next = (cur_row_q == ROW_LAST) ? 5'd0 : cur_row_q + 5'd1;

    function automatic cell_wr_t blank(input logic [4:0] r, input logic [6:0] c);
        return '{row: r, col: c, ascii: CC_SPACE, fg: DEF_FG, bg: DEF_BG};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLR_SCR;
            clr_row_q  <= '0;
            clr_col_q  <= '0;
            clr_done_q <= 1'b0;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            we_q       <= 1'b0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            clr_row_q  <= clr_row_d;
            clr_col_q  <= clr_col_d;
            clr_done_q <= clr_done_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            we_q       <= we_d;
            wr_q       <= wr_d;
        end
    end

    // clr_done marks that the final clear write has been issued; the FSM
    // lingers one more cycle so in_ready rises only after that write.
    always_comb begin
        state_d    = state_q;
        clr_row_d  = clr_row_q;
        clr_col_d  = clr_col_q;
        clr_done_d = clr_done_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        we_d       = 1'b0;
        wr_d       = wr_q;
        new_line   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    unique case (1'b1)
                        is_print: begin
                            we_d = 1'b1;
                            wr_d = '{row: cur_row_q, col: cur_col_q,
                                     ascii: in_data, fg: cfg_fg, bg: cfg_bg};
                            if (cur_col_q < COL_LAST)
                                cur_col_d = cur_col_q + 7'd1;
                            else
                                new_line = 1'b1;
                        end
                        (in_data == CC_LF): new_line = 1'b1;
                        (in_data == CC_CR): cur_col_d = '0;
                        (in_data == CC_BS): begin
                            if (cur_col_q != 7'd0) begin
                                cur_col_d = cur_col_q - 7'd1;
                                we_d      = 1'b1;
                                wr_d      = blank(cur_row_q, cur_col_q - 7'd1);
                            end
                        end
                        (in_data == CC_FF): begin
                            state_d    = CLR_SCR;
                            clr_row_d  = '0;
                            clr_col_d  = '0;
                            clr_done_d = 1'b0;
                            cur_row_d  = '0;
                            cur_col_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            CLR_LINE: begin
                if (clr_done_q) begin
                    state_d = IDLE;
                end else begin
                    we_d = 1'b1;
                    wr_d = blank(cur_row_q, clr_col_q);
                    if (clr_col_q == COL_LAST)
                        clr_done_d = 1'b1;
                    else
                        clr_col_d = clr_col_q + 7'd1;
                end
            end
            CLR_SCR: begin
                if (clr_done_q) begin
                    state_d = IDLE;
                end else begin
                    we_d = 1'b1;
                    wr_d = blank(clr_row_q, clr_col_q);
                    if (clr_col_q == COL_LAST) begin
                        clr_col_d = '0;
                        if (clr_row_q == ROW_LAST)
                            clr_done_d = 1'b1;
                        else
                            clr_row_d = clr_row_q + 5'd1;
                    end else begin
                        clr_col_d = clr_col_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Any row change lands on a freshly cleared line.
        if (new_line) begin
            state_d    = CLR_LINE;
            cur_row_d  = row_next;
            cur_col_d  = '0;
            clr_col_d  = '0;
            clr_done_d = 1'b0;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign we         = we_q;
    assign wr_addr    = wr_q.row;
    assign wc_addr    = wr_q.col;
    assign w_ascii    = wr_q.ascii;
    assign w_fg_color = wr_q.fg;
    assign w_bg_color = wr_q.bg;
    assign cur_row    = cur_row_q;
    assign cur_col    = cur_col_q;

`ifdef VGA_CONSOLE_BLINK_EN
    vga_cursor_blink #(
        .BLINK_CYCLES(BLINK_CYCLES)
    ) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .reload(hs),
        .vis   (cur_vis)
    );
`else
    assign cur_vis = 1'b1;
`endif

endmodule

// File: tb/tb_vga_console_ctrl.sv
// tb_vga_console_ctrl: self-checking bench for vga_console_ctrl.
// Table vectors, hand-written clear/reset sequences and random byte streams.
module tb_vga_console_ctrl;

    localparam int ROWS = 30;
    localparam int COLS = 70;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [2:0] cfg_fg = 3'd0;
    logic [2:0] cfg_bg = 3'd0;
    logic       in_ready, we, cur_vis, busy;
    logic [4:0] wr_addr, cur_row;
    logic [6:0] wc_addr, cur_col;
    logic [7:0] w_ascii;
    logic [2:0] w_fg_color, w_bg_color;

    always #5 clk = ~clk;

    vga_console_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cfg_fg(cfg_fg), .cfg_bg(cfg_bg),
        .we(we), .wr_addr(wr_addr), .wc_addr(wc_addr), .w_ascii(w_ascii),
        .w_fg_color(w_fg_color), .w_bg_color(w_bg_color),
        .cur_row(cur_row), .cur_col(cur_col), .cur_vis(cur_vis), .busy(busy)
    );

    typedef struct {
        logic [4:0] r;
        logic [6:0] c;
        logic [7:0] a;
        logic [2:0] f;
        logic [2:0] b;
        int         cyc;
    } wr_t;

    wr_t act[$];
    wr_t expq[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  mrow = 0;
    int  mcol = 0;
    int  rdy_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (we) act.push_back('{wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color, cyc});

    function automatic wr_t mk(int r, int c, logic [7:0] a, logic [2:0] f, logic [2:0] b);
        wr_t w;
        w.r = 5'(r); w.c = 7'(c); w.a = a; w.f = f; w.b = b; w.cyc = 0;
        return w;
    endfunction

    function automatic int pk(wr_t w);
        return int'({w.r, w.c, w.a, w.f, w.b});
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Reference model: plain screen arithmetic producing the expected write list.
    task automatic push_blank(int r, int c);
        expq.push_back(mk(r, c, 8'h20, 3'd7, 3'd0));
    endtask

    task automatic model_clear_screen();
        mrow = 0; mcol = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) push_blank(r, c);
    endtask

    task automatic model_newline();
        mrow = (mrow + 1) % ROWS;
        mcol = 0;
        for (int c = 0; c < COLS; c++) push_blank(mrow, c);
    endtask

    task automatic model_byte(logic [7:0] d, logic [2:0] f, logic [2:0] b);
        if (d >= 8'h20 && d <= 8'h7E) begin
            expq.push_back(mk(mrow, mcol, d, f, b));
            if (mcol < COLS - 1) mcol++;
            else model_newline();
        end else if (d == 8'h0A) model_newline();
        else if (d == 8'h0D) mcol = 0;
        else if (d == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                push_blank(mrow, mcol);
            end
        end else if (d == 8'h0C) model_clear_screen();
    endtask

    task automatic send(logic [7:0] d, logic [2:0] f, logic [2:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; cfg_fg = f; cfg_bg = b;
        while (!in_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send timeout: in_ready stuck 0 for byte 0x%0h", d);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data = $urandom_range(0, 255);
        end
    endtask

    task automatic xfer(logic [7:0] d, logic [2:0] f, logic [2:0] b);
        send(d, f, b);
        model_byte(d, f, b);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        rdy_cyc = cyc;
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL idle timeout: in_ready got 0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic chk_seq(string name);
        int bad = -1;
        int n;
        chk({name, " count"}, act.size(), expq.size());
        n = (act.size() < expq.size()) ? act.size() : expq.size();
        for (int i = 0; i < n && bad < 0; i++)
            if (pk(act[i]) != pk(expq[i])) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s write %0d: got (%0d,%0d,%0h,%0d,%0d) expected (%0d,%0d,%0h,%0d,%0d)",
                     name, bad, act[bad].r, act[bad].c, act[bad].a, act[bad].f, act[bad].b,
                     expq[bad].r, expq[bad].c, expq[bad].a, expq[bad].f, expq[bad].b);
        end
    endtask

    function automatic int gaps();
        int g = 0;
        for (int i = 1; i < act.size(); i++)
            if (act[i].cyc != act[i-1].cyc + 1) g++;
        return g;
    endfunction

    task automatic goto(int r, int c);
        xfer(8'h0D, 3'd0, 3'd0);
        while (mrow != r) xfer(8'h0A, 3'd0, 3'd0);
        for (int i = 0; i < c; i++) xfer(8'h2E, 3'd7, 3'd0);
        wait_idle();
    endtask

    function automatic logic [7:0] rand_byte();
        int k = $urandom_range(0, 99);
        if (k < 70) return 8'($urandom_range(32, 126));
        if (k < 78) return 8'h0A;
        if (k < 83) return 8'h0D;
        if (k < 93) return 8'h08;
        if (k < 96) return 8'($urandom_range(128, 255));
        if (k < 98) return 8'($urandom_range(0, 7));
        return 8'h7F;
    endfunction

    typedef struct {
        int         sr, sc;
        logic [7:0] d;
        logic [2:0] f, b;
        int         n;
        int         er, ec;
        int         wr, wc;
        logic [7:0] wa;
        logic [2:0] wf, wb;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int nw;

        tbl[0] = '{0, 0,   8'h41, 3'd2, 3'd1,  1, 0, 1,  0, 0,  8'h41, 3'd2, 3'd1};
        tbl[1] = '{3, 4,   8'h08, 3'd5, 3'd5,  1, 3, 3,  3, 3,  8'h20, 3'd7, 3'd0};
        tbl[2] = '{3, 0,   8'h08, 3'd5, 3'd5,  0, 3, 0,  0, 0,  8'h00, 3'd0, 3'd0};
        tbl[3] = '{5, 10,  8'h0D, 3'd1, 3'd1,  0, 5, 0,  0, 0,  8'h00, 3'd0, 3'd0};
        tbl[4] = '{5, 69,  8'h7A, 3'd5, 3'd6, 71, 6, 0,  5, 69, 8'h7A, 3'd5, 3'd6};
        tbl[5] = '{6, 3,   8'h01, 3'd1, 3'd1,  0, 6, 3,  0, 0,  8'h00, 3'd0, 3'd0};
        tbl[6] = '{6, 3,   8'h7F, 3'd1, 3'd1,  0, 6, 3,  0, 0,  8'h00, 3'd0, 3'd0};
        tbl[7] = '{6, 3,   8'h7E, 3'd1, 3'd2,  1, 6, 4,  6, 3,  8'h7E, 3'd1, 3'd2};
        tbl[8] = '{29, 5,  8'h0A, 3'd4, 3'd4, 70, 0, 0,  0, 0,  8'h20, 3'd7, 3'd0};
        tbl[9] = '{29, 69, 8'h71, 3'd3, 3'd4, 71, 0, 0,  29, 69, 8'h71, 3'd3, 3'd4};

        #12;
        chk("reset we", int'(we), 0);
        chk("reset wr_addr", int'(wr_addr), 0);
        chk("reset wc_addr", int'(wc_addr), 0);
        chk("reset w_ascii", int'(w_ascii), 0);
        chk("reset w_fg", int'(w_fg_color), 0);
        chk("reset w_bg", int'(w_bg_color), 0);
        chk("reset cur_row", int'(cur_row), 0);
        chk("reset cur_col", int'(cur_col), 0);
        chk("reset cur_vis", int'(cur_vis), 1);
        chk("reset in_ready", int'(in_ready), 0);
        chk("reset busy", int'(busy), 1);

        @(negedge clk);
        rst_n = 1'b1;
        act.delete(); expq.delete();
        model_clear_screen();
        wait_idle();
        chk_seq("power-on clear");
        if (act.size() > 0) begin
            chk("power-on clear span", act[act.size()-1].cyc - act[0].cyc, ROWS * COLS - 1);
            chk("ready after last clear write", rdy_cyc - act[act.size()-1].cyc, 1);
        end
        chk("power-on cursor", int'({cur_row, cur_col}), 0);

        foreach (tbl[i]) begin
            goto(tbl[i].sr, tbl[i].sc);
            act.delete(); expq.delete();
            xfer(tbl[i].d, tbl[i].f, tbl[i].b);
            wait_idle();
            nw = act.size();
            chk($sformatf("vec%0d writes", i), nw, tbl[i].n);
            if (tbl[i].n > 0 && nw > 0)
                chk($sformatf("vec%0d first write", i), pk(act[0]),
                    pk(mk(tbl[i].wr, tbl[i].wc, tbl[i].wa, tbl[i].wf, tbl[i].wb)));
            if (tbl[i].n > 1 && nw > 1) begin
                chk($sformatf("vec%0d last write", i), pk(act[nw-1]),
                    pk(mk(tbl[i].er, COLS - 1, 8'h20, 3'd7, 3'd0)));
                chk($sformatf("vec%0d contiguous", i), gaps(), 0);
            end
            chk($sformatf("vec%0d cur_row", i), int'(cur_row), tbl[i].er);
            chk($sformatf("vec%0d cur_col", i), int'(cur_col), tbl[i].ec);
        end

        // A full row of printables from column 0, back to back.
        goto(0, 0);
        act.delete(); expq.delete();
        for (int i = 0; i < COLS; i++)
            xfer(8'($urandom_range(32, 126)), 3'($urandom), 3'($urandom));
        wait_idle();
        chk_seq("full row");
        if (act.size() >= COLS + 1) begin
            chk("full row last char col", int'(act[COLS-1].c), COLS - 1);
            chk("full row no gap", act[COLS].cyc - act[COLS-1].cyc, 1);
        end
        chk("full row one write per cycle", gaps(), 0);
        chk("full row cur_row", int'(cur_row), 1);
        chk("full row cur_col", int'(cur_col), 0);

        for (int blk = 0; blk < 4; blk++) begin
            act.delete(); expq.delete();
            for (int i = 0; i < 100; i++)
                xfer(rand_byte(), 3'($urandom), 3'($urandom));
            wait_idle();
            chk_seq($sformatf("random%0d", blk));
            chk($sformatf("random%0d cur_row", blk), int'(cur_row), mrow);
            chk($sformatf("random%0d cur_col", blk), int'(cur_col), mcol);
        end

        // Form feed, then reset in the middle of the clear.
        act.delete(); expq.delete();
        send(8'h0C, 3'd0, 3'd0);
        nw = 0;
        while (act.size() < 500 && nw < 3000) begin
            @(negedge clk);
            #1;
            nw++;
        end
        chk("ff writes before reset", act.size(), 500);
        if (act.size() > 0)
            chk("ff first clear write", pk(act[0]), pk(mk(0, 0, 8'h20, 3'd7, 3'd0)));
        chk("ff we before reset", int'(we), 1);
        rst_n = 1'b0;
        #1;
        chk("abort we", int'(we), 0);
        chk("abort busy", int'(busy), 1);
        chk("abort in_ready", int'(in_ready), 0);
        repeat (3) @(negedge clk);
        act.delete(); expq.delete();
        rst_n = 1'b1;
        model_clear_screen();
        wait_idle();
        chk_seq("clear after reset");
        if (act.size() > 0)
            chk("clear after reset span", act[act.size()-1].cyc - act[0].cyc, ROWS * COLS - 1);
        chk("clear after reset cursor", int'({cur_row, cur_col}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
